// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting ports, the arbiter and the shared single-port memory.
// The arbiter uses the slave view; the requesters and the memory model use the master view.
interface mem_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_wen;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_q,
    output i_ack, i_rdata, d_ack, d_rdata, mem_wen, mem_a, mem_d, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_q,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_wen, mem_a, mem_d, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between an instruction
// port (read-only) and a data port; one transaction per four cycles.
module mem_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e        state_q;
  logic          last_grant_q;  // 1: D port was granted last
  logic          winner_q;
  logic          wen_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic          busy_q;
  logic          mem_wen_q;
  logic [AW-1:0] mem_a_q;
  logic [DW-1:0] mem_d_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          grant_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_d = bus.d_req & (~bus.i_req | ~last_grant_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      wen_q        <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_a_q      <= '0;
      mem_d_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_req || bus.d_req) begin
            winner_q     <= grant_d;
            last_grant_q <= grant_d;
            wen_q        <= grant_d & bus.d_wen;
            mem_wen_q    <= grant_d & bus.d_wen;
            mem_a_q      <= grant_d ? bus.d_addr[AW+1:2] : bus.i_addr[AW+1:2];
            if (grant_d) begin
              mem_d_q <= bus.d_wdata;
            end
            busy_q  <= 1'b1;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          mem_wen_q <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          // mem_q now reflects the address the memory sampled at the end of ACCESS.
          if (winner_q) begin
            d_ack_q <= 1'b1;
            if (!wen_q) begin
              d_rdata_q <= bus.mem_q;
            end
          end else begin
            i_ack_q   <= 1'b1;
            i_rdata_q <= bus.mem_q;
          end
          state_q <= StDone;
        end
        StDone: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.mem_wen = mem_wen_q;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_d   = mem_d_q;
  assign bus.busy    = busy_q;

  // Byte-lane and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:AW+2], bus.i_addr[1:0],
                              bus.d_addr[31:AW+2], bus.d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, expected-ack scoreboard, directed
// scenarios for latency, round-robin order, write path and reset abort.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous memory: address sampled at the edge, data visible the following cycle.
  logic [DW-1:0] mem [32];
  bit            loaded;

  function automatic logic [31:0] init_word(input int k);
    logic [31:0] w;
    w = (k == 2) ? 32'h2000_0004 : (32'hA500_0000 | k);
    return w;
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 32; k++) mem[k] <= init_word(k);
      loaded <= 1'b1;
    end else begin
      if (bus.mem_wen) mem[bus.mem_a] <= bus.mem_d;
      bus.mem_q <= mem[bus.mem_a];
    end
  end

  typedef struct {
    bit          port;  // 1 = D
    bit          wen;
    logic [31:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            ack_cnt = 0;
  int            wen_cnt = 0;
  logic [AW-1:0] wen_a;
  logic [DW-1:0] wen_d;
  logic [DW-1:0] i_model;
  logic [DW-1:0] d_model;

  always @(negedge clk) begin
    exp_t e;
    if (bus.i_ack || bus.d_ack) begin
      ack_cnt++;
      check("ack_overlap", {63'd0, bus.i_ack & bus.d_ack}, 64'd0);
      check("sb_has_entry", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ack_port", {63'd0, bus.d_ack}, {63'd0, e.port});
        if (e.port) begin
          if (e.wen) begin
            check("d_rdata_kept", bus.d_rdata, d_model);
          end else begin
            check("d_rdata", bus.d_rdata, e.data);
            d_model = e.data;
          end
        end else begin
          check("i_rdata", bus.i_rdata, e.data);
          i_model = e.data;
        end
      end
    end
    if (bus.mem_wen) begin
      wen_cnt++;
      wen_a = bus.mem_a;
      wen_d = bus.mem_d;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_i_ack"},   {63'd0, bus.i_ack},   64'd0);
    check({tag, "_d_ack"},   {63'd0, bus.d_ack},   64'd0);
    check({tag, "_busy"},    {63'd0, bus.busy},    64'd0);
    check({tag, "_mem_wen"}, {63'd0, bus.mem_wen}, 64'd0);
    check({tag, "_mem_a"},   {59'd0, bus.mem_a},   64'd0);
    check({tag, "_mem_d"},   {32'd0, bus.mem_d},   64'd0);
    check({tag, "_i_rdata"}, {32'd0, bus.i_rdata}, 64'd0);
    check({tag, "_d_rdata"}, {32'd0, bus.d_rdata}, 64'd0);
  endtask

  // Enter at posedge+1; returns at posedge+1 with rst_n released.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    i_model = '0;
    d_model = '0;
  endtask

  // Single transaction on one port; entered and left at posedge+1.
  task automatic do_txn(input bit port, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    int n;
    logic [31:0] a;
    a = addr;
    exp_q.push_back('{port, wen, exp_rd});
    if (port) begin
      bus.d_req   = 1'b1;
      bus.d_wen   = wen;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end else begin
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
    end
    @(posedge clk);
    @(negedge clk);
    n = 1;
    check("access_busy", {63'd0, bus.busy}, 64'd1);
    check("access_mem_a", {59'd0, bus.mem_a}, {59'd0, a[AW+1:2]});
    check("access_mem_wen", {63'd0, bus.mem_wen}, {63'd0, port & wen});
    if (port && wen) check("access_mem_d", {32'd0, bus.mem_d}, {32'd0, wdata});
    while (!(port ? bus.d_ack : bus.i_ack) && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("ack_latency", n, 3);
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  // Requests already driven at posedge+1; expects n acks, first after 3 cycles, then every 4.
  task automatic wait_acks(input int n);
    int seen;
    int last;
    int t;
    int a0;
    seen = 0;
    last = 0;
    t    = 0;
    @(posedge clk);
    while (seen < n && t < 8 * n + 8) begin
      @(negedge clk);
      t++;
      if (bus.i_ack || bus.d_ack) begin
        check(seen == 0 ? "first_latency" : "ack_spacing", t - last, seen == 0 ? 3 : 4);
        last = t;
        seen++;
      end
    end
    check("acks_seen", seen, n);
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    a0 = ack_cnt;
    repeat (8) @(negedge clk);
    check("no_extra_ack", ack_cnt, a0);
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    rst_n       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wen   = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    i_model     = '0;
    d_model     = '0;
    @(posedge clk);
    #1;
    do_reset();

    // I read of word 2 with d_wen high on the idle D port: must stay a read.
    w0 = wen_cnt;
    bus.d_wen = 1'b1;
    do_txn(1'b0, 1'b0, 32'h0000_0008, '0, 32'h2000_0004);
    check("i_no_write", wen_cnt, w0);
    bus.d_wen = 1'b0;

    // High and byte-lane address bits dropped.
    do_txn(1'b0, 1'b0, 32'hFFFF_FF8B, '0, 32'h2000_0004);

    // D write then read back.
    w0 = wen_cnt;
    do_txn(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, '0);
    check("wr_pulse_count", wen_cnt, w0 + 1);
    check("wr_mem_a", {59'd0, wen_a}, 64'd4);
    check("wr_mem_d", {32'd0, wen_d}, 64'hDEAD_BEEF);
    do_txn(1'b1, 1'b0, 32'h0000_0010, '0, 32'hDEAD_BEEF);

    // D held through its own DONE: two separate transactions, 4 cycles apart.
    exp_q.push_back('{1'b1, 1'b0, init_word(5)});
    exp_q.push_back('{1'b1, 1'b0, init_word(5)});
    bus.d_wen  = 1'b0;
    bus.d_addr = 32'h0000_0014;
    bus.d_req  = 1'b1;
    wait_acks(2);

    // Tie from reset: I, D, I, D.
    do_reset();
    exp_q.push_back('{1'b0, 1'b0, init_word(3)});
    exp_q.push_back('{1'b1, 1'b0, init_word(5)});
    exp_q.push_back('{1'b0, 1'b0, init_word(3)});
    exp_q.push_back('{1'b1, 1'b0, init_word(5)});
    bus.i_addr = 32'h0000_000C;
    bus.d_addr = 32'h0000_0014;
    bus.d_wen  = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    wait_acks(4);
    check("sb_drained", exp_q.size(), 0);

    // Reset during WAIT of a D read: no ack, everything cleared.
    bus.d_req  = 1'b1;
    bus.d_wen  = 1'b0;
    bus.d_addr = 32'h0000_0014;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("wait_abort");
    d_model = '0;
    i_model = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset during ACCESS of a write: that write lands, nothing follows.
    w0 = wen_cnt;
    bus.d_req   = 1'b1;
    bus.d_wen   = 1'b1;
    bus.d_addr  = 32'h0000_0018;
    bus.d_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.d_req = 1'b0;
    bus.d_wen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("access_abort");
    @(posedge clk);
    #1;
    check("abort_wr_count", wen_cnt, w0 + 1);
    check("abort_wr_landed", {32'd0, mem[6]}, 64'h1234_5678);
    rst_n = 1'b1;
    // Request presented in the first cycle out of reset.
    do_txn(1'b1, 1'b0, 32'h0000_0018, '0, 32'h1234_5678);
    check("abort_no_late_wr", wen_cnt, w0 + 1);

    check("sb_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
